// File: rtl/mult_cdb_buffer_pkg.sv
// Shared constants and packed types for the multiply result buffer.
// Latency and backpressure: none, this file holds types only.
package mult_cdb_buffer_pkg;

  localparam int MULT_LAT   = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int TAG_W      = 6;
  localparam int ROB_W      = 5;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [ROB_W-1:0] rob;
  } mult_tag_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [ROB_W-1:0] rob;
    logic [63:0]      value;
  } mult_result_t;

  // Pointer increment that wraps at a power-of-two depth.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1) % depth;
  endfunction

endpackage

// File: rtl/mult_cdb_buffer_if.sv
// Issue-side and CDB-side handshake bundle of the multiply result buffer.
// Latency: none, wires only; backpressure carried by issue_ready and cdb_grant.
interface mult_cdb_buffer_if;
  import mult_cdb_buffer_pkg::*;

  logic             issue_valid;
  logic [TAG_W-1:0] issue_tag;
  logic [ROB_W-1:0] issue_rob;
  logic             issue_ready;

  logic             cdb_req;
  logic             cdb_grant;
  logic [TAG_W-1:0] cdb_tag;
  logic [ROB_W-1:0] cdb_rob;
  logic [63:0]      cdb_value;

  // master: the RS issue port plus the CDB arbiter; slave: the buffer itself.
  modport master (
    output issue_valid, issue_tag, issue_rob, cdb_grant,
    input  issue_ready, cdb_req, cdb_tag, cdb_rob, cdb_value
  );

  modport slave (
    input  issue_valid, issue_tag, issue_rob, cdb_grant,
    output issue_ready, cdb_req, cdb_tag, cdb_rob, cdb_value
  );

endinterface

// File: rtl/mult_cdb_buffer_tag_shadow.sv
// Shift register of {valid,tag,rob} running alongside the multiplier pipeline.
// Latency: LAT cycles load-to-last; no backpressure, flush clears every valid.
module mult_cdb_buffer_tag_shadow
  import mult_cdb_buffer_pkg::*;
#(
  parameter int LAT   = MULT_LAT,
  parameter int CNT_W = $clog2(LAT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  mult_tag_t        load,
  output mult_tag_t        last,
  output logic [CNT_W-1:0] inflight
);

  mult_tag_t stage [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) stage[i] <= '0;
      inflight <= '0;
    end else if (flush) begin
      for (int i = 0; i < LAT; i++) stage[i] <= '0;
      inflight <= '0;
    end else begin
      stage[0] <= load;
      for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
      // The last stage always shifts out, so its valid bit always leaves the count.
      inflight <= inflight + CNT_W'(load.valid) - CNT_W'(stage[LAT-1].valid);
    end
  end

  assign last = stage[LAT-1];

endmodule

// File: rtl/mult_cdb_buffer.sv
// Tracks tags of in-flight multiplies, captures products and queues them for the CDB.
// Latency: issue to cdb_req is LAT+1 cycles; issue_ready drops when in-flight plus buffered reaches DEPTH.
module mult_cdb_buffer
  import mult_cdb_buffer_pkg::*;
#(
  parameter int LAT   = MULT_LAT,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  mult_cdb_buffer_if.slave         bus,
  output logic                     mult_start,
  input  logic                     mult_done,
  input  logic [63:0]              mult_product
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IF_W  = $clog2(LAT + 1);
  localparam int CR_W  = $clog2(LAT + DEPTH + 1);

  mult_tag_t         shadow_load;
  mult_tag_t         shadow_last;
  logic [IF_W-1:0]   inflight;

  mult_result_t      mem [DEPTH];
  mult_result_t      head_entry;
  mult_result_t      push_entry;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  fifo_count;
  logic [CR_W-1:0]   credits;
  logic              push;
  logic              pop;

  // Credits come from registers only so issue_ready never combinationally depends on grant.
  assign credits         = CR_W'(inflight) + CR_W'(fifo_count);
  assign bus.issue_ready = (credits < CR_W'(DEPTH));
  assign mult_start      = bus.issue_valid & bus.issue_ready & ~flush;

  always_comb begin
    shadow_load       = '0;
    shadow_load.valid = mult_start;
    shadow_load.tag   = bus.issue_tag;
    shadow_load.rob   = bus.issue_rob;
  end

  mult_cdb_buffer_tag_shadow #(
    .LAT   (LAT),
    .CNT_W (IF_W)
  ) u_shadow (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .load     (shadow_load),
    .last     (shadow_last),
    .inflight (inflight)
  );

  // A done with an invalid shadow entry belongs to a squashed op and is dropped here.
  assign push = mult_done & shadow_last.valid & ~flush;
  assign pop  = bus.cdb_grant & (fifo_count != '0) & ~flush;

  always_comb begin
    push_entry       = '0;
    push_entry.tag   = shadow_last.tag;
    push_entry.rob   = shadow_last.rob;
    push_entry.value = mult_product;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head       <= '0;
      tail       <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      head       <= '0;
      tail       <= '0;
      fifo_count <= '0;
    end else begin
      if (push) tail <= PTR_W'(wrap_inc(32'(tail), DEPTH));
      if (pop)  head <= PTR_W'(wrap_inc(32'(head), DEPTH));
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage is not reset; the head is only exposed while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_entry;
  end

  assign head_entry    = mem[head];
  assign bus.cdb_req   = (fifo_count != '0);
  assign bus.cdb_tag   = bus.cdb_req ? head_entry.tag   : '0;
  assign bus.cdb_rob   = bus.cdb_req ? head_entry.rob   : '0;
  assign bus.cdb_value = bus.cdb_req ? head_entry.value : '0;

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (fifo_count == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_mult_cdb_buffer.sv
module tb_mult_cdb_buffer;
  import mult_cdb_buffer_pkg::*;

  localparam int LAT   = 4;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        mult_start;
  logic        mult_done;
  logic [63:0] mult_product;
  logic [31:0] mcand;
  logic [31:0] mplier;

  mult_cdb_buffer_if bus ();

  mult_cdb_buffer #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .bus          (bus),
    .mult_start   (mult_start),
    .mult_done    (mult_done),
    .mult_product (mult_product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the external multiplier: fixed LAT-cycle pipe, reset with the buffer.
  logic        mp_vld  [LAT];
  logic [63:0] mp_prod [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        mp_vld[i]  <= 1'b0;
        mp_prod[i] <= '0;
      end
    end else begin
      mp_vld[0]  <= mult_start;
      mp_prod[0] <= {32'b0, mcand} * {32'b0, mplier};
      for (int i = 1; i < LAT; i++) begin
        mp_vld[i]  <= mp_vld[i-1];
        mp_prod[i] <= mp_prod[i-1];
      end
    end
  end
  assign mult_done    = mp_vld[LAT-1];
  assign mult_product = mp_prod[LAT-1];

  // Reference: every accepted op is outstanding until granted; it becomes
  // visible on the CDB LAT+1 cycles after the cycle it was accepted in.
  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [ROB_W-1:0] rob;
    logic [63:0]      value;
    int               arrive;
  } exp_t;

  exp_t q[$];
  int   outstanding;
  int   cyc;
  int   n_chk;
  int   n_pass;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic cycle(input logic iv, input logic [TAG_W-1:0] tg, input logic [ROB_W-1:0] rb,
                       input logic [31:0] a, input logic [31:0] b, input logic gr,
                       input logic fl, output logic accepted);
    logic exp_ready, exp_start, exp_req;
    exp_t e;
    bus.issue_valid = iv;
    bus.issue_tag   = tg;
    bus.issue_rob   = rb;
    bus.cdb_grant   = gr;
    mcand           = a;
    mplier          = b;
    flush           = fl;
    exp_ready = (outstanding < DEPTH);
    exp_start = iv & exp_ready & ~fl;
    exp_req   = (q.size() != 0) && (q[0].arrive <= cyc);
    @(negedge clk);
    chk("issue_ready", 64'(bus.issue_ready), 64'(exp_ready));
    chk("mult_start", 64'(mult_start), 64'(exp_start));
    chk("cdb_req", 64'(bus.cdb_req), 64'(exp_req));
    if (exp_req) begin
      chk("cdb_tag", 64'(bus.cdb_tag), 64'(q[0].tag));
      chk("cdb_rob", 64'(bus.cdb_rob), 64'(q[0].rob));
      chk("cdb_value", bus.cdb_value, q[0].value);
    end
    @(posedge clk);
    if (fl) begin
      q.delete();
      outstanding = 0;
    end else begin
      if (exp_req && gr) begin
        void'(q.pop_front());
        outstanding--;
      end
      if (exp_start) begin
        e.tag    = tg;
        e.rob    = rb;
        e.value  = 64'(a) * 64'(b);
        e.arrive = cyc + LAT + 1;
        q.push_back(e);
        outstanding++;
      end
    end
    cyc++;
    accepted = exp_start;
    #1;
  endtask

  task automatic idle(input int n, input logic gr);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 32'd0, 32'd0, gr, 1'b0, acc);
  endtask

  task automatic issue_until_accepted(input logic [TAG_W-1:0] tg, input logic [ROB_W-1:0] rb,
                                      input logic gr);
    logic acc;
    int   tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 40) begin
      cycle(1'b1, tg, rb, 32'(tg) + 32'd3, 32'(rb) + 32'd11, gr, 1'b0, acc);
      tries++;
    end
    chk("issue_accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic reset_mid_cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cdb_req", 64'(bus.cdb_req), 64'd0);
    chk("rst_issue_ready", 64'(bus.issue_ready), 64'd1);
    chk("rst_cdb_value", bus.cdb_value, 64'd0);
    bus.issue_valid = 1'b0;
    bus.cdb_grant   = 1'b0;
    flush           = 1'b0;
    q.delete();
    outstanding = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic acc;
    n_chk = 0;
    n_pass = 0;
    cyc = 0;
    outstanding = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    mcand = '0;
    mplier = '0;
    bus.issue_valid = 1'b0;
    bus.issue_tag = '0;
    bus.issue_rob = '0;
    bus.cdb_grant = 1'b0;

    @(negedge clk);
    chk("reset_issue_ready", 64'(bus.issue_ready), 64'd1);
    chk("reset_mult_start", 64'(mult_start), 64'd0);
    chk("reset_cdb_req", 64'(bus.cdb_req), 64'd0);
    chk("reset_cdb_tag", 64'(bus.cdb_tag), 64'd0);
    chk("reset_cdb_rob", 64'(bus.cdb_rob), 64'd0);
    chk("reset_cdb_value", bus.cdb_value, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single op: 7*6 with tag 5, rob 3.
    cycle(1'b1, 6'd5, 5'd3, 32'd7, 32'd6, 1'b0, 1'b0, acc);
    idle(7, 1'b0);
    idle(3, 1'b1);

    // Fill to the credit limit, hold issue_valid, then free one slot.
    for (int i = 0; i < 4; i++) cycle(1'b1, 6'(i), 5'(i), 32'(i + 2), 32'd9, 1'b0, 1'b0, acc);
    for (int i = 0; i < 8; i++) cycle(1'b1, 6'd60, 5'd1, 32'd1, 32'd1, 1'b0, 1'b0, acc);
    cycle(1'b0, '0, '0, 32'd0, 32'd0, 1'b1, 1'b0, acc);
    idle(3, 1'b0);
    idle(12, 1'b1);

    // Stream of 16 with grant every cycle; covers FIFO pointer wrap.
    for (int i = 0; i < 16; i++) issue_until_accepted(6'(i), 5'(i), 1'b1);
    idle(12, 1'b1);

    // Flush with two buffered and two still in the multiplier.
    for (int i = 0; i < 4; i++) cycle(1'b1, 6'(10 + i), 5'(i), 32'd100, 32'(i), 1'b0, 1'b0, acc);
    idle(2, 1'b0);
    cycle(1'b0, '0, '0, 32'd0, 32'd0, 1'b1, 1'b1, acc);
    idle(8, 1'b0);
    cycle(1'b1, 6'd9, 5'd4, 32'd123, 32'd456, 1'b0, 1'b0, acc);
    idle(7, 1'b0);
    idle(3, 1'b1);

    // Asynchronous reset in the middle of a busy stream.
    for (int i = 0; i < 7; i++) cycle(1'b1, 6'(20 + i), 5'(i), 32'(i), 32'd5, i[0], 1'b0, acc);
    reset_mid_cycle();
    idle(2, 1'b0);

    // Randomised traffic: mixed issue/grant density with occasional flushes.
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 9) < 7), 6'($urandom), 5'($urandom), $urandom, $urandom,
            1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0), acc);
    end
    idle(12, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
